// File: rtl/sub_32bit_seq_pkg.sv
// rtl/sub_32bit_seq_pkg.sv - shared width, state encoding and clog2 helper for the sequential subtractor
package sub_32bit_seq_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sub_32bit_seq_if.sv
// rtl/sub_32bit_seq_if.sv - start/busy/done operand and result bundle of the sequential subtractor
interface sub_32bit_seq_if;
    import sub_32bit_seq_pkg::*;

    logic              start;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              bin;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] d;
    logic              bout;
    logic              ovf;
    logic              zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout, ovf, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout, ovf, zero
    );

endinterface

// File: rtl/sub_32bit_seq_slice.sv
// rtl/sub_32bit_seq_slice.sv - combinational W-bit subtract slice with borrow in/out
module sub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] r,
    output logic         bo
);

    logic [W:0] sum;

    // a - b - bin as a + ~b + ~bin; a missing carry-out means a borrow
    assign sum = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~bin};
    assign r   = sum[W-1:0];
    assign bo  = ~sum[W];

endmodule

// File: rtl/sub_32bit_seq.sv
// rtl/sub_32bit_seq.sv - 32-bit subtractor processing one SLICE_W-bit slice per clock, LSB first
module sub_32bit_seq
    import sub_32bit_seq_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    sub_32bit_seq_if.slave bus
);

    localparam int NSLICE = WORD_W / SLICE_W;
    localparam int CNT_W  = (clog2(NSLICE) < 1) ? 1 : clog2(NSLICE);
    localparam logic [WORD_W-1:0] SLICE_MASK = WORD_W'({SLICE_W{1'b1}});

    state_t            state;
    state_t            state_n;
    logic              load;
    logic              step;
    logic              last;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] a_r;
    logic [WORD_W-1:0] b_r;
    logic              brw;
    logic [WORD_W-1:0] d_r;
    logic              busy_r;
    logic              done_r;
    logic              bout_r;
    logic              ovf_r;
    logic              zero_r;

    logic [WORD_W-1:0]  shamt;
    logic [SLICE_W-1:0] a_s;
    logic [SLICE_W-1:0] b_s;
    logic [SLICE_W-1:0] r_s;
    logic               bo_s;
    logic [WORD_W-1:0]  d_ins;

    assign shamt = WORD_W'(cnt) * WORD_W'(SLICE_W);
    assign a_s   = SLICE_W'(a_r >> shamt);
    assign b_s   = SLICE_W'(b_r >> shamt);
    assign last  = (cnt == CNT_W'(NSLICE - 1));

    sub_slice #(.W(SLICE_W)) u_slice (
        .a   (a_s),
        .b   (b_s),
        .bin (brw),
        .r   (r_s),
        .bo  (bo_s)
    );

    // d with the current slice result merged in; the final flags look at this full value
    assign d_ins = (d_r & ~(SLICE_MASK << shamt)) | (WORD_W'(r_s) << shamt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            brw    <= 1'b0;
            d_r    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            done_r <= step && last;
            if (load) begin
                a_r    <= bus.a;
                b_r    <= bus.b;
                brw    <= bus.bin;
                cnt    <= '0;
                d_r    <= '0;
                busy_r <= 1'b1;
                bout_r <= 1'b0;
                ovf_r  <= 1'b0;
                zero_r <= 1'b0;
            end else if (step) begin
                d_r <= d_ins;
                brw <= bo_s;
                cnt <= cnt + CNT_W'(1);
                if (last) begin
                    busy_r <= 1'b0;
                    bout_r <= bo_s;
                    ovf_r  <= (a_r[WORD_W-1] != b_r[WORD_W-1]) && (d_ins[WORD_W-1] != a_r[WORD_W-1]);
                    zero_r <= (d_ins == '0);
                end
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.d    = d_r;
    assign bus.bout = bout_r;
    assign bus.ovf  = ovf_r;
    assign bus.zero = zero_r;

endmodule

// File: tb/tb_sub_32bit_seq.sv
// tb/tb_sub_32bit_seq.sv - self-checking bench for sub_32bit_seq at SLICE_W = 1, 8 and 32
module tb_sub_32bit_seq;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    int          sel;
    int          nsl;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    logic        m_busy;
    logic        m_done;
    logic [31:0] m_d;
    logic        m_bout;
    logic        m_ovf;
    logic        m_zero;

    vec_t tbl[8];

    always #5 clk = ~clk;

    sub_32bit_seq_if bus1();
    sub_32bit_seq_if bus8();
    sub_32bit_seq_if bus32();

    assign bus1.start  = start;
    assign bus1.a      = a;
    assign bus1.b      = b;
    assign bus1.bin    = bin;
    assign bus8.start  = start;
    assign bus8.a      = a;
    assign bus8.b      = b;
    assign bus8.bin    = bin;
    assign bus32.start = start;
    assign bus32.a     = a;
    assign bus32.b     = b;
    assign bus32.bin   = bin;

    sub_32bit_seq #(.SLICE_W(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
    sub_32bit_seq #(.SLICE_W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    sub_32bit_seq #(.SLICE_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

    always_comb begin
        m_busy = bus8.busy;
        m_done = bus8.done;
        m_d    = bus8.d;
        m_bout = bus8.bout;
        m_ovf  = bus8.ovf;
        m_zero = bus8.zero;
        if (sel == 0) begin
            m_busy = bus1.busy;
            m_done = bus1.done;
            m_d    = bus1.d;
            m_bout = bus1.bout;
            m_ovf  = bus1.ovf;
            m_zero = bus1.zero;
        end else if (sel == 2) begin
            m_busy = bus32.busy;
            m_done = bus32.done;
            m_d    = bus32.d;
            m_bout = bus32.bout;
            m_ovf  = bus32.ovf;
            m_zero = bus32.zero;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s (slice_w=%0d): got %h expected %h", name, 32 / nsl, act, exp);
        end
    endtask

    // Reference: plain 33-bit unsigned subtraction, borrow is bit 32
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin,
                         output logic [31:0] md, output logic mbout, output logic movf,
                         output logic mzero);
        logic [32:0] t;
        t     = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
        md    = t[31:0];
        mbout = t[32];
        movf  = (ma[31] != mb[31]) && (md[31] != ma[31]);
        mzero = (md == 32'd0);
    endtask

    task automatic check_op(input string name, input logic [31:0] ta, input logic [31:0] tb,
                            input logic tbin, input logic [31:0] ed, input logic ebout,
                            input logic eovf, input logic ezero);
        int lat;
        start = 1'b1;
        a     = ta;
        b     = tb;
        bin   = tbin;
        tick();
        start = 1'b0;
        chk({name, "_busy"}, 32'(m_busy), 32'd1);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (m_done) begin
                lat = k;
                break;
            end
        end
        chk({name, "_latency"}, 32'(lat), 32'(nsl));
        chk({name, "_d"}, m_d, ed);
        chk({name, "_bout"}, 32'(m_bout), 32'(ebout));
        chk({name, "_ovf"}, 32'(m_ovf), 32'(eovf));
        chk({name, "_zero"}, 32'(m_zero), 32'(ezero));
        tick();
        chk({name, "_done_drop"}, 32'(m_done), 32'd0);
    endtask

    initial begin
        int          pulses;
        int          bad;
        logic [31:0] ed;
        logic        ebout;
        logic        eovf;
        logic        ezero;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rbin;
        logic        exp_done;

        tbl[0] = '{"small",      32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{"chain_1",    32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{"chain_all",  32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{"ovf_neg",    32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{"ovf_pos",    32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{"zero",       32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{"zero_bin",   32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{"max_minus",  32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        sel   = 1;
        nsl   = 4;

        for (int s = 0; s < 3; s++) begin
            sel = s;
            nsl = (s == 0) ? 32 : ((s == 1) ? 4 : 1);
            rst = 1'b1;
            tick();
            tick();
            rst = 1'b0;
            chk("reset_busy", 32'(m_busy), 32'd0);
            chk("reset_done", 32'(m_done), 32'd0);
            chk("reset_d", m_d, 32'd0);
            chk("reset_flags", {29'd0, m_bout, m_ovf, m_zero}, 32'd0);

            for (int i = 0; i < 8; i++) begin
                check_op(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].bin,
                         tbl[i].d, tbl[i].bout, tbl[i].ovf, tbl[i].zero);
            end

            for (int i = 0; i < 10; i++) begin
                ra   = $urandom;
                rb   = (i % 4 == 3) ? ra : $urandom;
                rbin = 1'($urandom_range(0, 1));
                model(ra, rb, rbin, ed, ebout, eovf, ezero);
                check_op("rand", ra, rb, rbin, ed, ebout, eovf, ezero);
            end

            if (nsl >= 3) begin
                start = 1'b1;
                a     = 32'd20;
                b     = 32'd7;
                bin   = 1'b0;
                tick();
                start = 1'b0;
                pulses = -1;
                for (int k = 1; k <= 100; k++) begin
                    tick();
                    if (k == 1) begin
                        start = 1'b1;
                        a     = 32'hFFFFFFFF;
                        b     = 32'd0;
                    end
                    if (k == 2) start = 1'b0;
                    if (m_done) begin
                        pulses = k;
                        break;
                    end
                end
                start = 1'b0;
                chk("ignored_start_latency", 32'(pulses), 32'(nsl));
                chk("ignored_start_d", m_d, 32'd13);
                tick();
            end

            // start held high: second operation accepted out of DONE
            start  = 1'b1;
            a      = 32'd50;
            b      = 32'd8;
            bin    = 1'b0;
            tick();
            a      = 32'd1000;
            b      = 32'd1;
            bin    = 1'b1;
            pulses = 0;
            bad    = 0;
            for (int k = 1; k <= 2 * nsl + 3; k++) begin
                tick();
                exp_done = (k == nsl) || (k == 2 * nsl + 1);
                if (m_done !== exp_done) bad++;
                if (m_done) pulses++;
                if (k == nsl) chk("b2b_first_d", m_d, 32'd42);
                if (k == 2 * nsl + 1) begin
                    chk("b2b_second_d", m_d, 32'd998);
                    start = 1'b0;
                end
            end
            start = 1'b0;
            chk("b2b_done_pattern", 32'(bad), 32'd0);
            chk("b2b_pulses", 32'(pulses), 32'd2);

            if (nsl >= 2) begin
                start = 1'b1;
                a     = 32'd100;
                b     = 32'd1;
                bin   = 1'b0;
                tick();
                start = 1'b0;
                tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("abort_busy", 32'(m_busy), 32'd0);
                chk("abort_done", 32'(m_done), 32'd0);
                chk("abort_d", m_d, 32'd0);
                chk("abort_flags", {29'd0, m_bout, m_ovf, m_zero}, 32'd0);
                pulses = 0;
                for (int k = 0; k < nsl + 3; k++) begin
                    tick();
                    if (m_done) pulses++;
                end
                chk("abort_no_done", 32'(pulses), 32'd0);
                check_op("after_abort", 32'd9, 32'd4, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);
            end

            rst   = 1'b1;
            start = 1'b1;
            a     = 32'd7;
            b     = 32'd2;
            tick();
            rst   = 1'b0;
            start = 1'b0;
            chk("rst_start_busy", 32'(m_busy), 32'd0);
            pulses = 0;
            for (int k = 0; k < nsl + 2; k++) begin
                tick();
                if (m_done) pulses++;
            end
            chk("rst_start_no_done", 32'(pulses), 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
